clk_reset_gen: RTL and testbench

- Parametrised clock/reset generation block for FPGA top levels.
- Turns the single board clock into NUM_CLOCKS independently programmable divided clocks, each with a one-cycle rising-edge strobe.
- Produces a boot reset held for RESET_CYCLES after board reset.
- Adds per-channel glitch-free divisor reload and run/pause control, so the controller can retime or stop a core clock without a rebuild.

---
 rtl/clk_reset_pkg.sv | 24 ++
 rtl/clk_reset_gen_if.sv | 44 ++++
 rtl/clk_div_channel.sv | 82 ++++++++
 rtl/clk_reset_gen.sv | 92 +++++++++
 tb/tb_clk_reset_gen.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_reset_pkg.sv
// -----------------------------------------------------------------------------
// clk_reset_pkg
// Shared types and helpers for the clock/reset generation block.
//   boot_state_e  : boot sequencer states (BOOT_HOLD, BOOT_DONE)
//   MAX_DIV_WIDTH : widest divisor the helper function accepts
//   div_nonzero() : maps a divisor of 0 onto 1 so a channel never stalls
// -----------------------------------------------------------------------------
package clk_reset_pkg;

  typedef enum logic {
    BOOT_HOLD = 1'b0,
    BOOT_DONE = 1'b1
  } boot_state_e;

  localparam int unsigned MAX_DIV_WIDTH = 32;

  // A divisor of 0 would mean "never wrap"; treat it as the fastest setting.
  function automatic logic [MAX_DIV_WIDTH-1:0] div_nonzero(
    input logic [MAX_DIV_WIDTH-1:0] div
  );
    return (div == '0) ? MAX_DIV_WIDTH'(1) : div;
  endfunction

endpackage

// File: rtl/clk_reset_gen_if.sv
// -----------------------------------------------------------------------------
// clk_reset_gen_if
// Control/status bundle of clk_reset_gen.
//   div_i       : half-period divisor per channel, channel k at [k*DIV_WIDTH +: DIV_WIDTH]
//   div_load_i  : per-channel load strobe
//   run_i       : per-channel run enable (0 = pause request)
//   clk_o       : divided clocks
//   clk_rise_o  : one-cycle strobe ahead of each clk_o rising edge
//   reset_o     : boot reset
//   boot_done_o : boot reset released
//   boot_state  : boot sequencer state, for observation
//
// Handshake: div_load_i[k] is a single-cycle valid with an implied ready that
// is always high; div_i is sampled in every cycle where div_load_i[k] = 1,
// and a load is never refused or back-pressured.
//
// Modports: master = controller driving the block, slave = clk_reset_gen.
// -----------------------------------------------------------------------------
interface clk_reset_gen_if #(
  parameter int NUM_CLOCKS = 2,
  parameter int DIV_WIDTH  = 8
);
  import clk_reset_pkg::*;

  logic [NUM_CLOCKS*DIV_WIDTH-1:0] div_i;
  logic [NUM_CLOCKS-1:0]           div_load_i;
  logic [NUM_CLOCKS-1:0]           run_i;
  logic [NUM_CLOCKS-1:0]           clk_o;
  logic [NUM_CLOCKS-1:0]           clk_rise_o;
  logic                            reset_o;
  logic                            boot_done_o;
  boot_state_e                     boot_state;

  modport master (
    output div_i, div_load_i, run_i,
    input  clk_o, clk_rise_o, reset_o, boot_done_o, boot_state
  );

  modport slave (
    input  div_i, div_load_i, run_i,
    output clk_o, clk_rise_o, reset_o, boot_done_o, boot_state
  );

endinterface

// File: rtl/clk_div_channel.sv
// -----------------------------------------------------------------------------
// clk_div_channel
// One divided-clock channel with glitch-free divisor reload and run/pause.
//   i_clk, i_reset : board clock, synchronous active-high reset
//   i_div          : new half-period divisor
//   i_div_load     : latch i_div into the pending register
//   i_run          : 1 = run, 0 = pause (high phase is always completed)
//   o_clk          : registered divided clock, 50% duty, period 2*D
//   o_clk_rise     : high in the cycle before o_clk goes 0 -> 1
// -----------------------------------------------------------------------------
module clk_div_channel
  import clk_reset_pkg::*;
#(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [DIV_WIDTH-1:0] i_div,
  input  logic                 i_div_load,
  input  logic                 i_run,
  output logic                 o_clk,
  output logic                 o_clk_rise
);

  localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(DEFAULT_DIV);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_active_div;
  logic [DIV_WIDTH-1:0] r_pend_div;
  logic                 r_pend_flag;
  logic                 r_clk;

  logic [DIV_WIDTH-1:0] w_div;
  logic                 w_advance;
  logic                 w_wrap;

  assign w_div     = DIV_WIDTH'(div_nonzero(MAX_DIV_WIDTH'(r_active_div)));
  // A high phase always runs to completion so a pause never leaves a runt.
  assign w_advance = i_run | r_clk;
  assign w_wrap    = (r_cnt == w_div - DIV_WIDTH'(1));

  assign o_clk      = r_clk;
  // Held low during reset: no edge follows a reset cycle.
  assign o_clk_rise = ~i_reset & ~r_clk & i_run & w_wrap;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt        <= '0;
      r_clk        <= 1'b0;
      r_active_div <= RST_DIV;
      r_pend_div   <= RST_DIV;
      r_pend_flag  <= 1'b0;
    end else begin
      if (i_div_load) r_pend_div <= i_div;

      if (w_advance) begin
        if (w_wrap) begin
          r_cnt <= '0;
          r_clk <= ~r_clk;
          if (r_clk) begin
            // End of a full period: the only safe point to change D.
            if (i_div_load)       r_active_div <= i_div;
            else if (r_pend_flag) r_active_div <= r_pend_div;
            r_pend_flag <= 1'b0;
          end else if (i_div_load) begin
            r_pend_flag <= 1'b1;
          end
        end else begin
          r_cnt <= r_cnt + DIV_WIDTH'(1);
          if (i_div_load) r_pend_flag <= 1'b1;
        end
      end else begin
        // Paused with clk low: nothing to glitch, so apply pending at once.
        r_cnt <= '0;
        if (r_pend_flag) r_active_div <= r_pend_div;
        r_pend_flag <= i_div_load;
      end
    end
  end

endmodule

// File: rtl/clk_reset_gen.sv
// -----------------------------------------------------------------------------
// clk_reset_gen
// Board-clock divider bank plus boot reset sequencer.
//   clk   : board clock (only clock domain)
//   reset : synchronous active-high reset
//   bus   : clk_reset_gen_if.slave (divisors, loads, run enables in;
//           divided clocks, rise strobes, boot reset, boot done out)
// reset_o stays high for RESET_CYCLES cycles after reset falls. Channels keep
// running during the boot hold so downstream synchronous resets see edges.
// -----------------------------------------------------------------------------
module clk_reset_gen
  import clk_reset_pkg::*;
#(
  parameter int NUM_CLOCKS   = 2,
  parameter int DIV_WIDTH    = 8,
  parameter int DEFAULT_DIV  = 1,
  parameter int RESET_CYCLES = 20,
  parameter int CNT_WIDTH    = $clog2(RESET_CYCLES + 1)
) (
  input logic             clk,
  input logic             reset,
  clk_reset_gen_if.slave  bus
);

  if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
    $error("clk_reset_gen: RESET_CYCLES must be at least 1");
  end

  // ---------------- boot sequencer ----------------
  boot_state_e          r_state;
  logic [CNT_WIDTH-1:0] r_boot_cnt;

  boot_state_e          w_next_state;
  logic [CNT_WIDTH-1:0] w_next_cnt;
  logic                 w_reset_o;
  logic                 w_boot_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= BOOT_HOLD;
      r_boot_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_boot_cnt <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_boot_cnt;
    w_reset_o    = 1'b1;
    w_boot_done  = 1'b0;
    case (r_state)
      BOOT_HOLD: begin
        w_next_cnt = r_boot_cnt + CNT_WIDTH'(1);
        if (r_boot_cnt == CNT_WIDTH'(RESET_CYCLES - 1)) w_next_state = BOOT_DONE;
      end
      BOOT_DONE: begin
        w_reset_o   = 1'b0;
        w_boot_done = 1'b1;
      end
      default: w_next_state = BOOT_HOLD;
    endcase
  end

  assign bus.reset_o     = w_reset_o;
  assign bus.boot_done_o = w_boot_done;
  assign bus.boot_state  = r_state;

  // ---------------- divider channels ----------------
  logic [NUM_CLOCKS-1:0] w_clk;
  logic [NUM_CLOCKS-1:0] w_rise;

  for (genvar k = 0; k < NUM_CLOCKS; k++) begin : g_ch
    clk_div_channel #(
      .DIV_WIDTH   (DIV_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_div      (bus.div_i[k*DIV_WIDTH +: DIV_WIDTH]),
      .i_div_load (bus.div_load_i[k]),
      .i_run      (bus.run_i[k]),
      .o_clk      (w_clk[k]),
      .o_clk_rise (w_rise[k])
    );
  end

  assign bus.clk_o      = w_clk;
  assign bus.clk_rise_o = w_rise;

endmodule

// File: tb/tb_clk_reset_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_reset_gen
// Bench for clk_reset_gen: boot release and restart, default divide, reload,
// zero divisor, pause/resume and simultaneous events on both channels.
// -----------------------------------------------------------------------------
module tb_clk_reset_gen;
  import clk_reset_pkg::*;

  localparam int NC  = 2;
  localparam int DW  = 8;
  localparam int DEF = 1;
  localparam int RC  = 20;
  localparam int EW  = 2 + 2*NC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  clk_reset_gen_if #(.NUM_CLOCKS(NC), .DIV_WIDTH(DW)) bus ();

  clk_reset_gen #(
    .NUM_CLOCKS   (NC),
    .DIV_WIDTH    (DW),
    .DEFAULT_DIV  (DEF),
    .RESET_CYCLES (RC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", tag, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int   m_left [NC];
  logic m_clk  [NC];
  int   m_act  [NC];
  int   m_pend [NC];
  logic m_flag [NC];
  int   m_boot;
  logic m_rst;

  function automatic int fixd(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_step(input logic rst_v, input logic [NC*DW-1:0] div_v,
                            input logic [NC-1:0] load_v, input logic [NC-1:0] run_v);
    int dk;
    if (rst_v) begin
      m_boot = 0;
      m_rst  = 1'b1;
      for (int k = 0; k < NC; k++) begin
        m_clk[k]  = 1'b0;
        m_act[k]  = DEF;
        m_pend[k] = DEF;
        m_flag[k] = 1'b0;
        m_left[k] = fixd(DEF);
      end
    end else begin
      if (m_rst) begin
        m_boot++;
        if (m_boot == RC) m_rst = 1'b0;
      end
      for (int k = 0; k < NC; k++) begin
        dk = int'(div_v[k*DW +: DW]);
        if (run_v[k] || m_clk[k]) begin
          if (m_left[k] == 1) begin
            if (m_clk[k]) begin
              if (load_v[k])   m_act[k] = dk;
              else if (m_flag[k]) m_act[k] = m_pend[k];
              m_flag[k] = 1'b0;
            end else if (load_v[k]) begin
              m_flag[k] = 1'b1;
            end
            m_clk[k]  = !m_clk[k];
            m_left[k] = fixd(m_act[k]);
          end else begin
            m_left[k]--;
            if (load_v[k]) m_flag[k] = 1'b1;
          end
        end else begin
          if (m_flag[k]) m_act[k] = m_pend[k];
          m_flag[k] = load_v[k];
          m_left[k] = fixd(m_act[k]);
        end
        if (load_v[k]) m_pend[k] = dk;
      end
    end
  endtask

  // ---------------- observation helpers ----------------
  int   last_rise   [NC];
  int   last_period [NC];
  logic prev_clk    [NC];
  int   lo_drives  = 0;
  bit   boot_seen  = 0;

  // ---------------- driver ----------------
  logic [NC*DW-1:0] cur_div = '0;
  logic [NC-1:0]    cur_run = '1;

  task automatic step(input logic rst_v, input logic [NC*DW-1:0] div_v,
                      input logic [NC-1:0] load_v, input logic [NC-1:0] run_v);
    logic [EW-1:0] e;
    logic [NC-1:0] ec, er;
    @(negedge clk);
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("reset_o",     32'(bus.reset_o),     32'(e[EW-1]));
      check_eq("boot_done_o", 32'(bus.boot_done_o), 32'(e[EW-2]));
      check_eq("clk_o",       32'(bus.clk_o),       32'(e[2*NC-1:NC]));
      check_eq("clk_rise_o",  32'(bus.clk_rise_o),  32'(e[NC-1:0]));
      if (!boot_seen && lo_drives > 0 && bus.reset_o == 1'b0) begin
        check_eq("boot_len", 32'(lo_drives), 32'(RC));
        boot_seen = 1;
      end
      for (int k = 0; k < NC; k++) begin
        if (bus.clk_o[k] && !prev_clk[k]) begin
          last_period[k] = cyc - last_rise[k];
          last_rise[k]   = cyc;
        end
        prev_clk[k] = bus.clk_o[k];
      end
    end
    reset          = rst_v;
    bus.div_i      = div_v;
    bus.div_load_i = load_v;
    bus.run_i      = run_v;
    if (rst_v) begin
      lo_drives = 0;
      boot_seen = 0;
    end else begin
      lo_drives++;
    end
    model_step(rst_v, div_v, load_v, run_v);
    for (int k = 0; k < NC; k++) begin
      ec[k] = m_clk[k];
      er[k] = !rst_v && !m_clk[k] && run_v[k] && (m_left[k] == 1);
    end
    exp_q.push_back({m_rst, !m_rst, ec, er});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, cur_div, '0, cur_run);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, cur_div, '0, cur_run);
  endtask

  task automatic load_ch(input int k, input int d);
    logic [NC-1:0] lm;
    lm = '0;
    lm[k] = 1'b1;
    cur_div[k*DW +: DW] = DW'(d);
    step(1'b0, cur_div, lm, cur_run);
  endtask

  task automatic load_both(input int d0, input int d1);
    cur_div[0 +: DW]  = DW'(d0);
    cur_div[DW +: DW] = DW'(d1);
    step(1'b0, cur_div, '1, cur_run);
  endtask

  // Advance until channel k's model sits in the given phase position.
  task automatic wait_model(input int k, input logic want_clk, input int want_left, input int budget);
    int n;
    n = 0;
    while (!(m_clk[k] == want_clk && m_left[k] == want_left) && n < budget) begin
      idle(1);
      n++;
    end
    if (!(m_clk[k] == want_clk && m_left[k] == want_left)) begin
      checks++;
      errors++;
      $display("FAIL wait_model ch%0d: got no phase match in %0d cycles, want match", k, budget);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c, n, r;
    bus.div_i      = '0;
    bus.div_load_i = '0;
    bus.run_i      = '1;
    for (int k = 0; k < NC; k++) begin
      last_rise[k]   = 0;
      last_period[k] = 0;
      prev_clk[k]    = 1'b0;
    end

    // Boot: 3 reset cycles, restart after 10 low cycles, then full release.
    do_reset(3);
    idle(10);
    do_reset(2);
    idle(30);

    // Default divide D=1: period 2.
    idle(6);
    check_eq("ch0_default_period", 32'(last_period[0]), 32'(2));

    // Reload: channel 1 to D=3, then load 5 in the middle of a high phase.
    load_ch(1, 3);
    idle(12);
    wait_model(1, 1'b1, 2, 50);
    load_ch(1, 5);
    idle(25);
    check_eq("ch1_reload_period", 32'(last_period[1]), 32'(10));

    // Zero divisor behaves as D=1.
    load_ch(1, 0);
    idle(30);
    check_eq("ch1_zero_period", 32'(last_period[1]), 32'(2));

    // Pause channel 0 (D=4) during the high phase, then resume.
    load_ch(0, 4);
    idle(20);
    wait_model(0, 1'b1, 2, 50);
    cur_run[0] = 1'b0;
    idle(12);
    cur_run[0] = 1'b1;
    c = cyc + 1;
    idle(1);
    n = 0;
    while (last_rise[0] <= c && n < 12) begin
      idle(1);
      n++;
    end
    check_eq("ch0_resume_latency", 32'(last_rise[0] - c), 32'(4));

    // Pause while low: channel 1 at D=1, drop run for a while.
    cur_run[1] = 1'b0;
    idle(8);
    cur_run[1] = 1'b1;
    idle(8);

    // Independence: D=2 / D=7 loaded together, then joint random loads/pauses.
    load_both(2, 7);
    idle(30);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 7);
      if (r == 0) begin
        cur_run = ~cur_run;
        idle(1);
      end else if (r == 1) begin
        load_both($urandom_range(0, 9), $urandom_range(0, 9));
      end else begin
        idle(1);
      end
    end
    cur_run = '1;
    load_both(2, 7);
    idle(50);
    check_eq("ch0_final_period", 32'(last_period[0]), 32'(4));
    check_eq("ch1_final_period", 32'(last_period[1]), 32'(14));

    idle(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
